// File: rtl/inst_mem_controller.sv
// inst_mem_controller: read-only burst engine that fetches BURST_LEN
// little-endian 32-bit instructions from a byte-wide RAM for the fetcher.
module inst_mem_controller #(
  parameter int BURST_LEN  = 8,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  enable_from_fetcher,
  input  logic [31:0]           address_from_fetcher,
  input  logic                  reset_from_fetcher,
  output logic [31:0]           inst_to_fetcher,
  output logic                  one_inst_finish_to_fetcher,
  output logic                  end_to_fetcher,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  output logic [7:0]            mem_dout,
  input  logic [7:0]            mem_din
);

  localparam int TOTAL_BYTES = 4 * BURST_LEN;
  localparam int CNT_WIDTH   = $clog2(TOTAL_BYTES + 1);

  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] base;
  logic [CNT_WIDTH-1:0]  issued_bytes;
  logic [CNT_WIDTH-1:0]  received_bytes;
  logic [7:0]            inst_cnt;
  logic                  inflight;
  logic                  data_valid;
  logic [23:0]           partial;

  // The RAM is only ever read.
  assign mem_wr   = 1'b0;
  assign mem_dout = 8'h00;

  // Burst sequencer: issues byte addresses, assembles words, strobes the fetcher.
  // An address driven on mem_a is captured by the RAM at the next edge and its
  // byte is sampled one edge later, hence the inflight -> data_valid pipeline.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state                      <= IDLE;
      base                       <= '0;
      issued_bytes               <= '0;
      received_bytes             <= '0;
      inst_cnt                   <= '0;
      inflight                   <= 1'b0;
      data_valid                 <= 1'b0;
      partial                    <= '0;
      mem_a                      <= '0;
      inst_to_fetcher            <= '0;
      one_inst_finish_to_fetcher <= 1'b0;
      end_to_fetcher             <= 1'b0;
    end else if (!rdy_in) begin
      one_inst_finish_to_fetcher <= 1'b0;
      end_to_fetcher             <= 1'b0;
      inflight                   <= 1'b0;
      data_valid                 <= 1'b0;
      if (state == READ) begin
        mem_a        <= base + ADDR_WIDTH'(received_bytes);
        issued_bytes <= received_bytes;
      end
    end else begin
      one_inst_finish_to_fetcher <= 1'b0;
      end_to_fetcher             <= 1'b0;
      case (state)
        IDLE: begin
          if (enable_from_fetcher && !reset_from_fetcher) begin
            base           <= ADDR_WIDTH'(address_from_fetcher);
            mem_a          <= ADDR_WIDTH'(address_from_fetcher);
            inflight       <= 1'b1;
            data_valid     <= 1'b0;
            issued_bytes   <= CNT_WIDTH'(1);
            received_bytes <= '0;
            inst_cnt       <= '0;
            state          <= READ;
          end
        end
        READ: begin
          if (reset_from_fetcher) begin
            inflight   <= 1'b0;
            data_valid <= 1'b0;
            state      <= IDLE;
          end else begin
            data_valid <= inflight;
            if (issued_bytes < CNT_WIDTH'(TOTAL_BYTES)) begin
              mem_a        <= base + ADDR_WIDTH'(issued_bytes);
              issued_bytes <= issued_bytes + CNT_WIDTH'(1);
              inflight     <= 1'b1;
            end else begin
              inflight <= 1'b0;
            end
            if (data_valid) begin
              received_bytes <= received_bytes + CNT_WIDTH'(1);
              case (received_bytes[1:0])
                2'd0: partial[7:0]   <= mem_din;
                2'd1: partial[15:8]  <= mem_din;
                2'd2: partial[23:16] <= mem_din;
                default: begin
                  inst_to_fetcher            <= {mem_din, partial};
                  one_inst_finish_to_fetcher <= 1'b1;
                  inst_cnt                   <= inst_cnt + 8'd1;
                  if (inst_cnt == 8'(BURST_LEN - 1)) begin
                    state <= DONE;
                  end
                end
              endcase
            end
          end
        end
        DONE: begin
          inflight   <= 1'b0;
          data_valid <= 1'b0;
          if (!reset_from_fetcher) begin
            end_to_fetcher <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_controller.sv
// tb_inst_mem_controller: directed bench with a transaction-level model of
// the burst protocol and a per-cycle compare process.
module tb_inst_mem_controller;

  localparam int BURST_LEN  = 8;
  localparam int ADDR_WIDTH = 32;
  localparam int LOG_DEPTH  = 128;

  logic                  clk_in = 1'b0;
  logic                  rst_in = 1'b1;
  logic                  rdy_in = 1'b1;
  logic                  enable_from_fetcher = 1'b0;
  logic [31:0]           address_from_fetcher = '0;
  logic                  reset_from_fetcher = 1'b0;
  logic [31:0]           inst_to_fetcher;
  logic                  one_inst_finish_to_fetcher;
  logic                  end_to_fetcher;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic                  mem_wr;
  logic [7:0]            mem_dout;
  logic [7:0]            mem_din = '0;

  int tests_run    = 0;
  int tests_failed = 0;
  int edge_cnt     = 0;

  // Inputs as seen by the DUT at the most recent rising edge.
  logic        s_rst   = 1'b1;
  logic        s_rdy   = 1'b1;
  logic        s_en    = 1'b0;
  logic        s_abort = 1'b0;
  logic [31:0] s_addr  = '0;

  // Protocol model state and observation logs.
  logic [31:0] exp_q[$];
  bit          busy     = 1'b0;
  bit          end_due  = 1'b0;
  logic [31:0] last_inst = '0;
  int          accept_cnt  = 0;
  int          accept_edge = 0;
  int          end_cnt     = 0;
  int          end_edge    = 0;
  int          pulse_cnt   = 0;
  logic [31:0] pulse_log[LOG_DEPTH];
  int          pulse_edge[LOG_DEPTH];

  always #5 clk_in = ~clk_in;

  inst_mem_controller #(
    .BURST_LEN (BURST_LEN),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk_in                    (clk_in),
    .rst_in                    (rst_in),
    .rdy_in                    (rdy_in),
    .enable_from_fetcher       (enable_from_fetcher),
    .address_from_fetcher      (address_from_fetcher),
    .reset_from_fetcher        (reset_from_fetcher),
    .inst_to_fetcher           (inst_to_fetcher),
    .one_inst_finish_to_fetcher(one_inst_finish_to_fetcher),
    .end_to_fetcher            (end_to_fetcher),
    .mem_a                     (mem_a),
    .mem_wr                    (mem_wr),
    .mem_dout                  (mem_dout),
    .mem_din                   (mem_din)
  );

  // RAM contents: XOR-fold of the address, so 0x00..0xFF map to themselves.
  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24];
  endfunction

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return {ram_byte(a + 32'd3), ram_byte(a + 32'd2), ram_byte(a + 32'd1), ram_byte(a)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: actual %h required %h (edge %0d)", name, actual, expected, edge_cnt);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [31:0] addr, input logic abort, input logic rdy);
    @(posedge clk_in);
    #1;
    enable_from_fetcher  = en;
    address_from_fetcher = addr;
    reset_from_fetcher   = abort;
    rdy_in               = rdy;
  endtask

  // Waits for an end pulse within budget cycles; optionally drops enable
  // before the following edge, the way the fetcher reacts to end.
  task automatic waitEnd(input string name, input int budget, input bit drop_enable);
    int start = end_cnt;
    bit seen  = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk_in);
      #1;
      if (end_cnt != start) seen = 1'b1;
    end
    if (drop_enable) enable_from_fetcher = 1'b0;
    checkOutput(name, {31'd0, seen}, 32'd1);
  endtask

  // RAM with one cycle of read latency.
  always @(posedge clk_in) mem_din <= ram_byte(mem_a);

  // Edge counter and input capture at each rising edge.
  always @(posedge clk_in) begin
    edge_cnt <= edge_cnt + 1;
    s_rst    <= rst_in;
    s_rdy    <= rdy_in;
    s_en     <= enable_from_fetcher;
    s_abort  <= reset_from_fetcher;
    s_addr   <= address_from_fetcher;
  end

  // Compare process: after each edge, check outputs against the model.
  initial begin
    forever begin
      @(negedge clk_in);
      if (end_to_fetcher === 1'b1) begin
        end_cnt++;
        end_edge = edge_cnt;
      end
      if (one_inst_finish_to_fetcher === 1'b1 && pulse_cnt < LOG_DEPTH) begin
        pulse_log[pulse_cnt]  = inst_to_fetcher;
        pulse_edge[pulse_cnt] = edge_cnt;
        pulse_cnt++;
      end
      if (s_rst) begin
        checkOutput("rst_finish", {31'd0, one_inst_finish_to_fetcher}, 32'd0);
        checkOutput("rst_end", {31'd0, end_to_fetcher}, 32'd0);
        checkOutput("rst_inst", inst_to_fetcher, 32'd0);
        checkOutput("rst_mem_a", mem_a, 32'd0);
        exp_q.delete();
        busy      = 1'b0;
        end_due   = 1'b0;
        last_inst = '0;
      end else if (!s_rdy) begin
        checkOutput("pause_finish", {31'd0, one_inst_finish_to_fetcher}, 32'd0);
        checkOutput("pause_end", {31'd0, end_to_fetcher}, 32'd0);
        checkOutput("pause_inst", inst_to_fetcher, last_inst);
      end else if (busy && s_abort) begin
        checkOutput("abort_finish", {31'd0, one_inst_finish_to_fetcher}, 32'd0);
        checkOutput("abort_end", {31'd0, end_to_fetcher}, 32'd0);
        checkOutput("abort_inst", inst_to_fetcher, last_inst);
        exp_q.delete();
        busy    = 1'b0;
        end_due = 1'b0;
      end else if (!busy) begin
        checkOutput("idle_finish", {31'd0, one_inst_finish_to_fetcher}, 32'd0);
        checkOutput("idle_end", {31'd0, end_to_fetcher}, 32'd0);
        checkOutput("idle_inst", inst_to_fetcher, last_inst);
        if (s_en && !s_abort) begin
          busy        = 1'b1;
          accept_edge = edge_cnt;
          accept_cnt++;
          for (int i = 0; i < BURST_LEN; i++) exp_q.push_back(ram_word(s_addr + 32'(4 * i)));
        end
      end else begin
        checkOutput("end_strobe", {31'd0, end_to_fetcher}, {31'd0, end_due});
        if (end_due) begin
          end_due = 1'b0;
          busy    = 1'b0;
        end
        if (one_inst_finish_to_fetcher === 1'b1) begin
          if (exp_q.size() == 0) begin
            checkOutput("extra_finish", 32'd1, 32'd0);
          end else begin
            checkOutput("inst_value", inst_to_fetcher, exp_q[0]);
            last_inst = exp_q.pop_front();
            if (exp_q.size() == 0) end_due = 1'b1;
          end
        end else begin
          checkOutput("inst_hold", inst_to_fetcher, last_inst);
        end
      end
      checkOutput("mem_wr", {31'd0, mem_wr}, 32'd0);
      checkOutput("mem_dout", {24'd0, mem_dout}, 32'd0);
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios with hand-computed expectations.
  initial begin
    int b;
    int a0;
    int e0;
    int e1;

    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;
    @(negedge clk_in);
    checkOutput("post_reset_inst", inst_to_fetcher, 32'h0);
    checkOutput("post_reset_mem_a", mem_a, 32'h0);

    // Full burst from 0x0: latency, spacing, data, end.
    b = pulse_cnt;
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b1);
    waitEnd("t1_end_seen", 100, 1'b1);
    checkOutput("t1_pulses", 32'(pulse_cnt - b), 32'd8);
    checkOutput("t1_word0", pulse_log[b], 32'h03020100);
    checkOutput("t1_word1", pulse_log[b + 1], 32'h07060504);
    checkOutput("t1_word7", pulse_log[b + 7], 32'h1F1E1D1C);
    checkOutput("t1_first_latency", 32'(pulse_edge[b] - accept_edge), 32'd5);
    for (int i = 1; i < BURST_LEN; i++)
      checkOutput("t1_spacing", 32'(pulse_edge[b + i] - pulse_edge[b + i - 1]), 32'd4);
    checkOutput("t1_end_offset", 32'(end_edge - pulse_edge[b + 7]), 32'd1);

    // Abort six cycles after acceptance at 0x100.
    b  = pulse_cnt;
    e0 = end_cnt;
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b1);
    repeat (6) @(posedge clk_in);
    #1;
    reset_from_fetcher  = 1'b1;
    enable_from_fetcher = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    repeat (20) @(posedge clk_in);
    checkOutput("t2_pulses", 32'(pulse_cnt - b), 32'd1);
    checkOutput("t2_word0", pulse_log[b], 32'h02030001);
    checkOutput("t2_no_end", 32'(end_cnt - e0), 32'd0);

    // Fresh request after the abort.
    b = pulse_cnt;
    applyStimulus(1'b1, 32'h200, 1'b0, 1'b1);
    waitEnd("t2b_end_seen", 100, 1'b1);
    checkOutput("t2b_pulses", 32'(pulse_cnt - b), 32'd8);
    checkOutput("t2b_word0", pulse_log[b], 32'h01000302);

    // rdy_in low for three edges after two bytes of word 1.
    b = pulse_cnt;
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b1);
    repeat (8) @(posedge clk_in);
    #1 rdy_in = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    checkOutput("t3_pause_mem_a", mem_a, 32'h106);
    repeat (2) @(posedge clk_in);
    #1 rdy_in = 1'b1;
    waitEnd("t3_end_seen", 100, 1'b1);
    checkOutput("t3_pulses", 32'(pulse_cnt - b), 32'd8);
    checkOutput("t3_word0", pulse_log[b], 32'h02030001);
    checkOutput("t3_word1", pulse_log[b + 1], 32'h06070405);

    // Address wrap at the top of memory.
    b = pulse_cnt;
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    waitEnd("t4_end_seen", 100, 1'b1);
    checkOutput("t4_word0", pulse_log[b], 32'h00010203);
    checkOutput("t4_word1", pulse_log[b + 1], 32'h03020100);
    checkOutput("t4_word2", pulse_log[b + 2], 32'h07060504);

    // Enable held one cycle past end: exactly one re-acceptance.
    b  = pulse_cnt;
    a0 = accept_cnt;
    e0 = end_cnt;
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b1);
    waitEnd("t5_end1_seen", 100, 1'b0);
    e1 = end_edge;
    applyStimulus(1'b0, 32'h40, 1'b0, 1'b1);
    waitEnd("t5_end2_seen", 100, 1'b0);
    checkOutput("t5_accepts", 32'(accept_cnt - a0), 32'd2);
    checkOutput("t5_reaccept_edge", 32'(accept_edge - e1), 32'd1);
    checkOutput("t5_pulses", 32'(pulse_cnt - b), 32'd16);
    checkOutput("t5_ends", 32'(end_cnt - e0), 32'd2);
    checkOutput("t5_word8", pulse_log[b + 8], 32'h43424140);

    // enable and reset_from_fetcher together in IDLE: ignored.
    a0 = accept_cnt;
    applyStimulus(1'b1, 32'h300, 1'b1, 1'b1);
    repeat (4) @(posedge clk_in);
    @(negedge clk_in);
    checkOutput("t5_both_mem_a", mem_a, 32'h5F);
    checkOutput("t5_both_accepts", 32'(accept_cnt - a0), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);

    // rst_in during word 3.
    b  = pulse_cnt;
    e0 = end_cnt;
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b1);
    repeat (15) @(posedge clk_in);
    #1 rst_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    checkOutput("t6_inst_zero", inst_to_fetcher, 32'h0);
    checkOutput("t6_mem_a_zero", mem_a, 32'h0);
    @(posedge clk_in);
    #1;
    rst_in              = 1'b0;
    enable_from_fetcher = 1'b0;
    repeat (40) @(posedge clk_in);
    checkOutput("t6_pulses", 32'(pulse_cnt - b), 32'd3);
    checkOutput("t6_word2", pulse_log[b + 2], 32'h0B0A0908);
    checkOutput("t6_no_end", 32'(end_cnt - e0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
